// File: rtl/time_manager.sv
// Global next-event arbiter: finds the earliest generator time, drives it back as
// time_next while running, and provides idle / free-run / budgeted-run control.
module time_manager #(
  parameter  int N_CLKS = 2,
  parameter  int TW     = 32,
  parameter  int CW     = 32,
  localparam int IW     = (N_CLKS > 1) ? $clog2(N_CLKS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CLKS-1:0][TW-1:0]  time_in,
  input  logic                       run_start,
  input  logic                       run_stop,
  input  logic                       step_req,
  input  logic [CW-1:0]              step_count,
  output logic [TW-1:0]              time_next,
  output logic [IW-1:0]              win_idx,
  output logic [TW-1:0]              emu_time,
  output logic [TW-1:0]              dt,
  output logic [CW-1:0]              steps_done,
  output logic                       running,
  output logic                       done,
  output logic                       time_err
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RUN_FREE   = 2'd1,
    RUN_BUDGET = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] budget_q, budget_d;
  logic [TW-1:0] emu_time_q, emu_time_d;
  logic [TW-1:0] dt_q, dt_d;
  logic [CW-1:0] steps_done_q, steps_done_d;
  logic          done_q, done_d;
  logic          time_err_q, time_err_d;

  logic [TW-1:0] min_val;
  logic [IW-1:0] min_idx;
  logic          step;

  // Strict less-than keeps the earliest index on ties.
  always_comb begin
    min_val = time_in[0];
    min_idx = '0;
    for (int i = 1; i < N_CLKS; i++) begin
      if (time_in[i] < min_val) begin
        min_val = time_in[i];
        min_idx = IW'(i);
      end
    end
  end

  assign step = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    budget_d     = budget_q;
    emu_time_d   = emu_time_q;
    dt_d         = dt_q;
    steps_done_d = steps_done_q;
    done_d       = 1'b0;
    time_err_d   = time_err_q;

    if (step) begin
      emu_time_d   = min_val;
      dt_d         = min_val - emu_time_q;
      steps_done_d = steps_done_q + CW'(1);
      if (min_val < emu_time_q) time_err_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (run_stop) begin
          state_d = IDLE;
        end else if (step_req) begin
          if (step_count == '0) begin
            done_d = 1'b1;
          end else begin
            budget_d = step_count;
            state_d  = RUN_BUDGET;
          end
        end else if (run_start) begin
          state_d = RUN_FREE;
        end
      end
      RUN_FREE: begin
        if (run_stop) state_d = IDLE;
      end
      RUN_BUDGET: begin
        budget_d = budget_q - CW'(1);
        if (run_stop) begin
          state_d = IDLE;
        end else if (budget_q == CW'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      budget_q     <= '0;
      emu_time_q   <= '0;
      dt_q         <= '0;
      steps_done_q <= '0;
      done_q       <= 1'b0;
      time_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      budget_q     <= budget_d;
      emu_time_q   <= emu_time_d;
      dt_q         <= dt_d;
      steps_done_q <= steps_done_d;
      done_q       <= done_d;
      time_err_q   <= time_err_d;
    end
  end

  // The all-ones sentinel in IDLE keeps every generator from matching.
  assign time_next  = step ? min_val : '1;
  assign win_idx    = min_idx;
  assign emu_time   = emu_time_q;
  assign dt         = dt_q;
  assign steps_done = steps_done_q;
  assign running    = step;
  assign done       = done_q;
  assign time_err   = time_err_q;

endmodule
